// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns N debounced button levels into one stream of
// SHORT / LONG / REPEAT events behind a one-entry valid/ready register.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_btn_lvl      debounced levels, 1 = pressed
//   i_evt_ready    consumer accepts when o_evt_valid is also 1
//   o_evt_valid    event present
//   o_evt_id       index of the originating button
//   o_evt_type     00 SHORT, 01 LONG, 10 REPEAT
//   i_clr_ovf      clears o_overflow
//   o_overflow     sticky: an event was dropped
//
// Build option: BTN_EVT_REPEAT_EN enables REPEAT events while held.
module btn_event_ctrl #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int LONG_TICKS   = 800,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         i_btn_lvl,
    input  logic                     i_evt_ready,
    output logic                     o_evt_valid,
    output logic [$clog2(N_BTN)-1:0] o_evt_id,
    output logic [1:0]               o_evt_type,
    input  logic                     i_clr_ovf,
    output logic                     o_overflow
);

    localparam int ID_W   = $clog2(N_BTN);
    localparam int IDX_W  = ID_W + 1;
    localparam int HC_MAX = (LONG_TICKS > REPEAT_TICKS) ?
                            LONG_TICKS : REPEAT_TICKS;
    localparam int HC_W   = $clog2(HC_MAX + 1);
    localparam int HCX_W  = HC_W + 1;
    localparam int TC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TC_W-1:0]  TC_LAST = TC_W'(TICK_DIV - 1);
    localparam logic [HC_W:0]    LONG_N  = HCX_W'(LONG_TICKS);
    localparam logic [ID_W:0]    N_LIM   = IDX_W'(N_BTN);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_BTN - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

    localparam logic [1:0] T_SHORT  = 2'b00;
    localparam logic [1:0] T_LONG   = 2'b01;
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [1:0] T_REPEAT = 2'b10;
    localparam logic [HC_W:0] REP_N = HCX_W'(REPEAT_TICKS);
`endif

    logic [TC_W-1:0]  tick_cnt;
    logic             tick;
    logic [N_BTN-1:0] lvl_q;

    logic [1:0]       st_q     [N_BTN];
    logic [1:0]       st_d     [N_BTN];
    logic [HC_W-1:0]  hc_q     [N_BTN];
    logic [HC_W-1:0]  hc_d     [N_BTN];
    logic [HC_W:0]    hc_inc   [N_BTN];
    logic [1:0]       evt_type [N_BTN];
    logic [N_BTN-1:0] evt;

    logic [N_BTN-1:0] pend_q;
    logic [1:0]       ptype_q  [N_BTN];

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W:0]    cand;
    logic             gnt_any;
    logic             load;
    logic [N_BTN-1:0] gnt;
    logic             ovf_set;

    // Shared timebase
    assign tick = (tick_cnt == TC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TC_W'(1);
        end
    end

    // Per-button press classifier; release beats a same-cycle tick
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            st_d[i]     = st_q[i];
            hc_d[i]     = hc_q[i];
            hc_inc[i]   = {1'b0, hc_q[i]} + HCX_W'(1);
            evt[i]      = 1'b0;
            evt_type[i] = T_SHORT;
            case (st_q[i])
                S_IDLE: begin
                    if (i_btn_lvl[i] && !lvl_q[i]) begin
                        st_d[i] = S_PRESSED;
                        hc_d[i] = '0;
                    end
                end
                S_PRESSED: begin
                    if (!i_btn_lvl[i]) begin
                        evt[i]      = 1'b1;
                        evt_type[i] = T_SHORT;
                        st_d[i]     = S_IDLE;
                    end else if (tick) begin
                        if (hc_inc[i] == LONG_N) begin
                            evt[i]      = 1'b1;
                            evt_type[i] = T_LONG;
                            st_d[i]     = S_HELD;
                            hc_d[i]     = '0;
                        end else begin
                            hc_d[i] = hc_inc[i][HC_W-1:0];
                        end
                    end
                end
                S_HELD: begin
                    if (!i_btn_lvl[i]) begin
                        st_d[i] = S_IDLE;
`ifdef BTN_EVT_REPEAT_EN
                    end else if (tick) begin
                        if (hc_inc[i] == REP_N) begin
                            evt[i]      = 1'b1;
                            evt_type[i] = T_REPEAT;
                            hc_d[i]     = '0;
                        end else begin
                            hc_d[i] = hc_inc[i][HC_W-1:0];
                        end
`endif
                    end
                end
                default: st_d[i] = S_IDLE;
            endcase
        end
    end

    // Level history starts at all ones so a button held through
    // reset needs a release before it can register a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= '1;
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i] <= S_IDLE;
                hc_q[i] <= '0;
            end
        end else begin
            lvl_q <= i_btn_lvl;
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i] <= st_d[i];
                hc_q[i] <= hc_d[i];
            end
        end
    end

    // Round-robin search from ptr_q, wrapping modulo N_BTN
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand = {1'b0, ptr_q} + IDX_W'(k);
            if (cand >= N_LIM) begin
                cand = cand - N_LIM;
            end
            if (!gnt_any && pend_q[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    assign load = !o_evt_valid || i_evt_ready;

    always_comb begin
        gnt = '0;
        if (load && gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // A slot being granted this cycle can take a fresh event
    assign ovf_set = |(evt & pend_q & ~gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                ptype_q[i] <= T_SHORT;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (evt[i] && (!pend_q[i] || gnt[i])) begin
                    pend_q[i]  <= 1'b1;
                    ptype_q[i] <= evt_type[i];
                end else if (gnt[i]) begin
                    pend_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_evt_valid <= 1'b0;
            o_evt_id    <= '0;
            o_evt_type  <= T_SHORT;
            ptr_q       <= '0;
        end else if (load && gnt_any) begin
            o_evt_valid <= 1'b1;
            o_evt_id    <= gnt_idx;
            o_evt_type  <= ptype_q[gnt_idx];
            ptr_q       <= (gnt_idx == ID_LAST) ?
                           '0 : gnt_idx + ID_W'(1);
        end else if (i_evt_ready) begin
            o_evt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_overflow <= 1'b0;
        end else if (ovf_set) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Sequences and arbitrates N debounced button levels into a single event stream for the watch/stopwatch control unit.
- Per button: classifies presses as SHORT, LONG or auto-REPEAT, timed by one shared tick prescaler.
- Serialises simultaneous events through a round-robin arbiter into a one-entry valid/ready output register.

Parameters:
- N_BTN, 4, number of button inputs (2..8).
- TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz).
- LONG_TICKS, 800, ticks held before a LONG event.
- REPEAT_TICKS, 200, ticks between REPEAT events after LONG.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- i_btn_lvl  in  N_BTN  debounced button levels, 1 = pressed, synchronous to clk.
- i_evt_ready  in  1  consumer accepts the event on a cycle where o_evt_valid is also 1.
- o_evt_valid  out  1  event present.
- o_evt_id  out  ID_W=$clog2(N_BTN)  index of the button that generated the event.
- o_evt_type  out  2  event type: 00 SHORT, 01 LONG, 10 REPEAT, 11 reserved (never driven).
- i_clr_ovf  in  1  clears o_overflow.
- o_overflow  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset values:
  - o_evt_valid=0, o_evt_id=0, o_evt_type=0, o_overflow=0.
  - Tick counter=0; all pending flags=0; all FSMs IDLE.
  - Round-robin pointer=0, so button 0 has highest priority first.
  - Previous-level register=all ones.
- Reset mid-operation:
  - All state is discarded immediately.
  - A button held through reset produces nothing until it has been released and pressed again.
- Tick generator:
  - Counter 0..TICK_DIV-1.
  - tick=1 for exactly one clk cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
  - Free-running; shared by all buttons.
- Per-button FSM, with hold counter hc of width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1):
  - IDLE: on a rising edge (lvl=1, prev=0) → PRESSED, hc=0.
  - PRESSED:
    - lvl=0 → SHORT event, go IDLE.
    - Otherwise, on tick, hc+1. When hc+1 reaches LONG_TICKS → LONG event, go HELD, hc=0.
  - HELD:
    - lvl=0 → IDLE, no event.
    - On tick, hc+1. When it reaches REPEAT_TICKS → REPEAT event, hc=0, stay HELD.
  - Release has priority over a tick in the same cycle, so no LONG/REPEAT is issued on the release cycle.
- Pending stage:
  - An event sets pending[i]=1 and ptype[i]=type at the same clk edge the FSM transitions.
  - If pending[i] is already 1 and not granted that cycle, the new event is dropped and o_overflow is set.
  - If pending[i] is granted in the same cycle, the new event is stored and no overflow occurs.
- Arbiter / output register:
  - Load is allowed when the output register is empty or is being accepted (o_evt_valid & i_evt_ready).
  - On load, grant the first pending index at or after the pointer, wrapping around.
  - Load o_evt_id/o_evt_type, set o_evt_valid=1, clear that pending bit, and set pointer=granted+1 mod N_BTN.
  - Outputs stay stable while o_evt_valid=1 and i_evt_ready=0.
  - Latency: event edge at cycle t → o_evt_valid=1 after edge t+1, provided the output register is free.
  - Back-to-back: with i_evt_ready held at 1, one event is delivered per cycle.
- Overflow:
  - o_overflow is set as described under Pending stage and cleared by i_clr_ovf.
  - If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: BTN_EVT_REPEAT_EN.
- Defined: REPEAT events are generated as described above.
- Undefined:
  - HELD only waits for release; hc is idle.
  - Type 10 is never produced.
  - REPEAT_TICKS is unused.

Test Plan:
- Short press:
  - Setup: TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3; btn0 high for 10 clk, then low.
  - Expect: exactly one event, id=0, type=00; o_evt_valid asserts two edges after the falling level.
- Long hold with repeat:
  - Setup: same parameters, BTN_EVT_REPEAT_EN defined; btn2 held 40 clk.
  - Expect: LONG at tick 5 after press, then REPEAT every 3 ticks (12 clk), all with id=2.
  - Release: no event.
  - Macro undefined: only the LONG event.
- Simultaneous SHORT releases:
  - Stimulus: buttons 0, 1 and 3 release together; i_evt_ready=1.
  - Expect: ids 0, 1, 3 on three consecutive cycles.
  - Stimulus: a second simultaneous burst.
  - Expect: the order starts after the last granted index (0, 1, 3 again from pointer=0 wrap).
- Backpressure and overflow:
  - Stimulus: i_evt_ready=0; btn1 makes two short presses.
  - Expect: the first event sits in the output, stable; the second goes to pending.
  - Stimulus: a third press.
  - Expect: it is dropped and o_overflow=1.
  - Stimulus: i_clr_ovf pulse.
  - Expect: o_overflow=0.
- Reset mid-hold:
  - Stimulus: btn0 in PRESSED at hc=3; pulse rst; keep btn0 high.
  - Expect: all outputs 0 and no event ever.
  - Stimulus: release then press again.
  - Expect: normal SHORT.
- Release on tick cycle:
  - Stimulus: btn0 level falls on the same cycle as the tick that would reach LONG_TICKS.
  - Expect: SHORT only, no LONG.
